ps2_scan_decoder: RTL and testbench

Receives the raw PS/2 keyboard interface (ps2_clk, ps2_data) and turns it into one-cycle scan-code strobes on an 8-bit `key` bus. `key` is zero on every other cycle. It sits directly upstream of the entry controllers, which treat any non-zero `key` as "a key was pressed". The block strips break sequences (F0 xx) and extended prefixes (E0), so only make codes reach downstream logic.

---
 rtl/ps2_scan_decoder.sv | 178 +++++++++++++++++
 tb/tb_ps2_scan_decoder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_scan_decoder.sv
// PS/2 keyboard receiver. It synchronises and filters the raw pins and frames 11-bit words.
// Make codes come out as one-cycle strobes; break and extended prefixes are stripped.
module ps2_scan_decoder #(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] key,
    output logic       key_ext,
    output logic       frame_err
);

    localparam int unsigned FltW = $clog2(FILTER_LEN + 1);
    localparam int unsigned ToW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FltW-1:0] FltLast = FltW'(FILTER_LEN - 1);
    localparam logic [ToW-1:0]  ToLast  = ToW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

    logic            r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic            r_fclk;
    logic [FltW-1:0] r_flt_cnt, w_flt_cnt_d;
    logic            w_flip, w_fall;

    state_e          r_state, w_state_d;
    logic [7:0]      r_sr, w_sr_d;
    logic [2:0]      r_bitcnt, w_bitcnt_d;
    logic            r_parity, w_parity_d;
    logic [ToW-1:0]  r_to_cnt, w_to_cnt_d;
    logic            r_brk, w_brk_d, r_ext, w_ext_d;
    logic [7:0]      r_key, w_key_d;
    logic            r_key_ext, w_key_ext_d;
    logic            r_frame_err, w_frame_err_d;
    logic            w_timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_s1  <= 1'b1;
            r_clk_s2  <= 1'b1;
            r_dat_s1  <= 1'b1;
            r_dat_s2  <= 1'b1;
            r_fclk    <= 1'b1;
            r_flt_cnt <= '0;
        end else begin
            r_clk_s1  <= ps2_clk;
            r_clk_s2  <= r_clk_s1;
            r_dat_s1  <= ps2_data;
            r_dat_s2  <= r_dat_s1;
            r_fclk    <= r_fclk ^ w_flip;
            r_flt_cnt <= w_flt_cnt_d;
        end
    end

    // The fall strobe is raised in the cycle the filter commits to the new low level.
    always_comb begin
        w_flip      = 1'b0;
        w_flt_cnt_d = r_flt_cnt;
        if (r_clk_s2 == r_fclk) begin
            w_flt_cnt_d = '0;
        end else if (r_flt_cnt == FltLast) begin
            w_flip      = 1'b1;
            w_flt_cnt_d = '0;
        end else begin
            w_flt_cnt_d = r_flt_cnt + FltW'(1);
        end
    end

    assign w_fall    = w_flip & r_fclk;
    assign w_timeout = (r_state != StIdle) && (r_to_cnt == ToLast);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_sr        <= '0;
            r_bitcnt    <= '0;
            r_parity    <= 1'b0;
            r_to_cnt    <= '0;
            r_brk       <= 1'b0;
            r_ext       <= 1'b0;
            r_key       <= '0;
            r_key_ext   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_sr        <= w_sr_d;
            r_bitcnt    <= w_bitcnt_d;
            r_parity    <= w_parity_d;
            r_to_cnt    <= w_to_cnt_d;
            r_brk       <= w_brk_d;
            r_ext       <= w_ext_d;
            r_key       <= w_key_d;
            r_key_ext   <= w_key_ext_d;
            r_frame_err <= w_frame_err_d;
        end
    end

    always_comb begin
        w_state_d     = r_state;
        w_sr_d        = r_sr;
        w_bitcnt_d    = r_bitcnt;
        w_parity_d    = r_parity;
        w_brk_d       = r_brk;
        w_ext_d       = r_ext;
        w_key_d       = 8'h00;
        w_key_ext_d   = 1'b0;
        w_frame_err_d = 1'b0;

        if (r_state == StIdle || w_fall || w_timeout) begin
            w_to_cnt_d = '0;
        end else begin
            w_to_cnt_d = r_to_cnt + ToW'(1);
        end

        // Timeout takes priority over a coincident fall.
        if (w_timeout) begin
            w_state_d     = StIdle;
            w_frame_err_d = 1'b1;
            w_brk_d       = 1'b0;
            w_ext_d       = 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_fall && !r_dat_s2) begin
                        w_state_d  = StData;
                        w_bitcnt_d = '0;
                    end
                end
                StData: begin
                    if (w_fall) begin
                        w_sr_d     = {r_dat_s2, r_sr[7:1]};
                        w_bitcnt_d = r_bitcnt + 3'd1;
                        if (r_bitcnt == 3'd7) w_state_d = StParity;
                    end
                end
                StParity: begin
                    if (w_fall) begin
                        w_parity_d = r_dat_s2;
                        w_state_d  = StStop;
                    end
                end
                StStop: begin
                    if (w_fall) begin
                        w_state_d = StIdle;
                        if (r_dat_s2 && (^{r_sr, r_parity})) begin
                            if (r_sr == 8'hF0) begin
                                w_brk_d = 1'b1;
                            end else if (r_sr == 8'hE0) begin
                                w_ext_d = 1'b1;
                            end else if (r_brk) begin
                                w_brk_d = 1'b0;
                                w_ext_d = 1'b0;
                            end else if (r_sr == 8'h00 || r_sr == 8'hFF) begin
                                w_ext_d = 1'b0;
                            end else begin
                                w_key_d     = r_sr;
                                w_key_ext_d = r_ext;
                                w_ext_d     = 1'b0;
                            end
                        end else begin
                            w_frame_err_d = 1'b1;
                            w_brk_d       = 1'b0;
                            w_ext_d       = 1'b0;
                        end
                    end
                end
                default: w_state_d = StIdle;
            endcase
        end
    end

    assign key       = r_key;
    assign key_ext   = r_key_ext;
    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Randomised bench for ps2_scan_decoder: frames are driven at the pins and every output event
// is compared against a byte-level model of the prefix/break/error rules.
module tb_ps2_scan_decoder;

    localparam int unsigned FLT  = 2;
    localparam int unsigned TO   = 64;
    localparam int          HALF = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] key;
    logic       key_ext;
    logic       frame_err;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;

    int         ev_cyc[$];
    logic [7:0] ev_key[$];
    logic       ev_ext[$];
    logic       ev_err[$];

    logic m_brk = 1'b0;
    logic m_ext = 1'b0;

    ps2_scan_decoder #(
        .FILTER_LEN    (FLT),
        .TIMEOUT_CYCLES(TO)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .key      (key),
        .key_ext  (key_ext),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Any non-idle output value is an event; a key held for two cycles shows up twice.
    always @(negedge clk) begin
        if (key != 8'h00 || key_ext || frame_err) begin
            ev_cyc.push_back(cyc);
            ev_key.push_back(key);
            ev_ext.push_back(key_ext);
            ev_err.push_back(frame_err);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_events();
        ev_cyc.delete();
        ev_key.delete();
        ev_ext.delete();
        ev_err.delete();
    endtask

    task automatic model(input logic [7:0] b, input logic good, output logic any,
                         output logic [7:0] k, output logic e, output logic err);
        any = 1'b0;
        k   = 8'h00;
        e   = 1'b0;
        err = 1'b0;
        if (!good) begin
            any = 1'b1;
            err = 1'b1;
            m_brk = 1'b0;
            m_ext = 1'b0;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (m_brk) begin
            m_brk = 1'b0;
            m_ext = 1'b0;
        end else if (b == 8'h00 || b == 8'hFF) begin
            m_ext = 1'b0;
        end else begin
            any = 1'b1;
            k   = b;
            e   = m_ext;
            m_ext = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop,
                              input int nbits, output int stop_cyc);
        logic [10:0] bits;
        bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        stop_cyc = 0;
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            ps2_data = bits[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            if (i == 10) stop_cyc = cyc;
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
        end
        @(negedge clk);
        ps2_data = 1'b1;
    endtask

    task automatic send_and_check(input string tag, input logic [7:0] b, input logic bad_par,
                                  input logic bad_stop);
        int stop_cyc;
        logic any, e, err;
        logic [7:0] k;
        clear_events();
        send_frame(b, bad_par, bad_stop, 11, stop_cyc);
        repeat (FLT + 6) @(negedge clk);
        model(b, !(bad_par || bad_stop), any, k, e, err);
        check_eq({tag, "_events"}, ev_cyc.size(), any ? 1 : 0);
        if (any && ev_cyc.size() == 1) begin
            check_eq({tag, "_cycle"}, ev_cyc[0], stop_cyc + 2 + FLT);
            check_eq({tag, "_key"}, ev_key[0], k);
            check_eq({tag, "_ext"}, ev_ext[0], e);
            check_eq({tag, "_err"}, ev_err[0], err);
        end
    endtask

    initial begin
        int dummy;
        logic [7:0] b;
        int pre;
        logic bp, bs;

        repeat (3) @(negedge clk);
        check_eq("rst_key", key, 8'h00);
        check_eq("rst_ext", key_ext, 1'b0);
        check_eq("rst_err", frame_err, 1'b0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        send_and_check("make_1c", 8'h1C, 1'b0, 1'b0);
        send_and_check("brk_f0", 8'hF0, 1'b0, 1'b0);
        send_and_check("brk_1c", 8'h1C, 1'b0, 1'b0);
        send_and_check("make_24", 8'h24, 1'b0, 1'b0);
        send_and_check("ext_e0", 8'hE0, 1'b0, 1'b0);
        send_and_check("ext_74", 8'h74, 1'b0, 1'b0);
        send_and_check("extbrk_e0", 8'hE0, 1'b0, 1'b0);
        send_and_check("extbrk_f0", 8'hF0, 1'b0, 1'b0);
        send_and_check("extbrk_74", 8'h74, 1'b0, 1'b0);
        send_and_check("after_1c", 8'h1C, 1'b0, 1'b0);
        send_and_check("bad_par", 8'h1C, 1'b1, 1'b0);
        send_and_check("bad_stop", 8'h1C, 1'b0, 1'b1);
        send_and_check("make_43", 8'h43, 1'b0, 1'b0);
        send_and_check("err_ff", 8'hFF, 1'b0, 1'b0);
        send_and_check("err_00", 8'h00, 1'b0, 1'b0);

        // Timeout: abandon the frame after five data bits, with a pending break to be cleared.
        send_and_check("to_f0", 8'hF0, 1'b0, 1'b0);
        clear_events();
        send_frame(8'h5A, 1'b0, 1'b0, 6, dummy);
        repeat (TO + 10) @(negedge clk);
        check_eq("timeout_events", ev_cyc.size(), 1);
        if (ev_cyc.size() == 1) check_eq("timeout_err", ev_err[0], 1'b1);
        m_brk = 1'b0;
        m_ext = 1'b0;
        send_and_check("after_to_44", 8'h44, 1'b0, 1'b0);

        // A short low glitch with data low must not be taken as a start bit.
        clear_events();
        @(negedge clk);
        ps2_data = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (FLT - 1) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (HALF) @(negedge clk);
        ps2_data = 1'b1;
        repeat (FLT + 6) @(negedge clk);
        check_eq("glitch_events", ev_cyc.size(), 0);
        send_and_check("glitch_2b", 8'h2B, 1'b0, 1'b0);

        // Reset in the middle of a frame after an E0 prefix.
        send_and_check("rst_e0", 8'hE0, 1'b0, 1'b0);
        send_frame(8'h77, 1'b0, 1'b0, 5, dummy);
        clear_events();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("midrst_key", key, 8'h00);
        check_eq("midrst_ext", key_ext, 1'b0);
        check_eq("midrst_err", frame_err, 1'b0);
        rst_n = 1'b1;
        m_brk = 1'b0;
        m_ext = 1'b0;
        repeat (HALF * 4) @(negedge clk);
        check_eq("midrst_events", ev_cyc.size(), 0);
        send_and_check("after_rst_33", 8'h33, 1'b0, 1'b0);

        for (int i = 0; i < 24; i++) begin
            pre = $urandom_range(0, 3);
            if (pre == 1 || pre == 3) send_and_check("rnd_pre_e0", 8'hE0, 1'b0, 1'b0);
            if (pre >= 2) send_and_check("rnd_pre_f0", 8'hF0, 1'b0, 1'b0);
            b  = 8'($urandom_range(0, 255));
            bp = ($urandom_range(0, 7) == 0);
            bs = ($urandom_range(0, 7) == 0);
            send_and_check("rnd_byte", b, bp, bs);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
